// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one binary bit is folded into the BCD
// scratch register per clock, with the finished digits registered onto bcd.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = 4 * DIGITS;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        count_q, count_d;
  logic [BW-1:0]     scratch_q, scratch_d;
  logic [BW-1:0]     adj;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Add-3 correction on every digit before the shift, so a digit of 5..9
  // carries correctly into the next digit once doubled.
  always_comb begin
    adj = scratch_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // NOTE: every signal gets a default at the top of the block so that no
  // path through the case statement leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    scratch_d = scratch_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SHIFT;
          bin_d     = bin;
          scratch_d = '0;
          count_d   = 6'(WIDTH);
        end
      end
      S_SHIFT: begin
        scratch_d = {adj[BW-2:0], bin_q[WIDTH-1]};
        bin_d     = {bin_q[WIDTH-2:0], 1'b0};
        count_d   = count_q - 6'd1;
        if (count_q == 6'd1) begin
          // Only the completed value ever reaches bcd.
          state_d = S_IDLE;
          bcd_d   = scratch_d;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_SHIFT);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      scratch_q <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      scratch_q <= scratch_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bcd  = bcd_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential shift-and-add-3 (double-dabble) converter turning a WIDTH-bit unsigned binary value into DIGITS packed BCD digits. Each cycle it applies the add-3 correction to every BCD digit and then shifts one binary bit in, so one bit is processed per clock. It sits directly upstream of the BCD display path and feeds it digit-packed results under a start/busy/done handshake. It replaces the wide combinational add-3 array when area matters more than latency.

## Interface
- WIDTH, 8: binary input width; legal range 4–32.
- DIGITS, 3: number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH−1 (8→3, 16→5, 32→10).
- clk  input  1  rising-edge clock; the block uses this single clock only.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled on the clock edge, ignored unless idle.
- bin  input  WIDTH  unsigned binary operand; sampled only on an accepted start edge.
- bcd  output  4*DIGITS  result; digit k occupies bits [4k+3:4k], with digit 0 the least significant.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bcd is valid from this cycle onward.

## Operation
- FSM states: IDLE, SHIFT.
  - IDLE, start=1 → SHIFT.
  - SHIFT with count reaching 0 → IDLE.
- Accept: on an edge where the state is IDLE and start=1:
  - bin loads into the binary shift register.
  - The BCD scratch register clears to 0.
  - count loads WIDTH and busy goes to 1.
- SHIFT step, once per edge:
  - Each scratch digit d becomes d+3 (mod 16) if d≥5, otherwise it is unchanged.
  - The {scratch, binary} register then shifts left by 1; the binary MSB enters scratch bit 0.
  - count decrements.
  - Digit values ≥10 cannot occur in a correct conversion; the mod-16 rule still defines them.
- Completion: on the edge performing the WIDTH-th shift:
  - The final scratch value is registered into bcd.
  - done is driven to 1 for exactly one cycle.
  - busy goes to 0 and the state returns to IDLE.
- bcd holds its last result until the next completion. It is never updated with intermediate scratch values.
- start while busy=1 is ignored entirely; no queueing.
- Changes on bin after the accept edge have no effect on the result in flight.
- Reset, at any time including mid-conversion:
  - State goes to IDLE, count to 0, and the scratch and binary registers to 0.
  - Outputs: bcd=0, busy=0, done=0.
  - A conversion in flight is abandoned and no done pulse is produced.
- Counter width is wide enough to hold WIDTH (6 bits covers the legal range).

## Timing
- Accept edge E0 → busy=1 from E0 through E_WIDTH, i.e. exactly WIDTH cycles.
- Shifts occur on edges E1..E_WIDTH. done=1 and the new bcd are visible in the cycle after E_WIDTH.
- Latency from the accept edge to done: WIDTH cycles. With WIDTH=8, done is high in cycle 8 after the start cycle.
- done and busy are never high together.
- A start held high in the done cycle is accepted on the next edge. Back-to-back throughput is one conversion per WIDTH+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then bin=8'd0, start pulse → busy high for 8 cycles, then done pulse with bcd=12'h000.
- bin=8'd255 → done after 8 cycles, bcd=12'h255. Also bin=8'd99 → 12'h099 and bin=8'd100 → 12'h100.
- Exhaustive sweep of 0..255 using back-to-back starts (start held high) → each done shows the correct BCD, with spacing of 9 cycles between done pulses.
- Start pulses and bin changes in the middle of a conversion (bin=8'd37 accepted, then bin=8'd200 with start at cycle 3) → result is 12'h037 and no second conversion is started.
- Reset asserted at cycle 4 of a conversion of 8'd123 → next cycle bcd=0, busy=0, no done. A new start of 8'd42 → 12'h042.
- WIDTH=16, DIGITS=5, bin=16'd65535 → done after 16 cycles, bcd=20'h65535. Also bin=16'd10000 → 20'h10000.
